// File: rtl/rng_pkg.sv
// Shared definitions for the old-film random bank: channel FSM encoding, default
// feedback mask and the Fibonacci LFSR step used by every channel.
package rng_pkg;

    localparam int MAX_W = 32;
    localparam int DEF_WIDTH = 10;
    localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 10'b1100100001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Feedback is the parity of the tapped bits, shifted in at the MSB.
    function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int unsigned width);
        logic [MAX_W-1:0] fbv;
        fbv = MAX_W'(^(state & taps)) << (width - 1);
        return (state >> 1) | fbv;
    endfunction

endpackage

// File: rtl/lfsr_rand_bank_if.sv
// Frame-timing / effect-datapath side of the random bank: seeds and draw requests in,
// per-channel accepted values and status out.
interface lfsr_rand_bank_if #(
    parameter int WIDTH  = 10,
    parameter int NUM_CH = 4
);
    logic [NUM_CH*WIDTH-1:0] seed_i;
    logic                    frame_i;
    logic                    mode_i;
    logic [NUM_CH-1:0]       step_i;
    logic [NUM_CH*WIDTH-1:0] rand_o;
    logic [NUM_CH-1:0]       valid_o;
    logic                    busy_o;

    modport master (
        output seed_i, frame_i, mode_i, step_i,
        input  rand_o, valid_o, busy_o
    );

    modport slave (
        input  seed_i, frame_i, mode_i, step_i,
        output rand_o, valid_o, busy_o
    );
endinterface

// File: rtl/lfsr_rand_chan.sv
// One random channel: LFSR plus rejection sampler below LIMIT, forced accept after MAX_TRIES.
// Latency 1..MAX_TRIES cycles from the request edge; no backpressure, values simply hold.
module lfsr_rand_chan
    import rng_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(DEF_TAPS),
    parameter int                LIMIT     = 900,
    parameter int                MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             frame_i,
    input  logic             mode_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] rand_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [WIDTH:0]   LIMIT_W  = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH-1:0] LIMIT_LO = WIDTH'(LIMIT);
    localparam logic [TW-1:0]    TRIES_MX = TW'(MAX_TRIES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic             valid_q, valid_d;
    logic [TW-1:0]    tries_q, tries_d;

    logic [WIDTH-1:0] nxt;
    logic [TW-1:0]    tries_nxt;
    logic             do_step;
    logic             accept;
    logic             forced;

    assign nxt = WIDTH'(lfsr_step(MAX_W'(lfsr_q), MAX_W'(TAPS), WIDTH));

    // A new frame restarts the try budget so a long rejection run cannot leak across frames.
    assign tries_nxt = (frame_i ? '0 : tries_q) + 1'b1;
    assign do_step   = frame_i || (state_q == ST_GEN) ||
                       (mode_i && step_i && (state_q == ST_DONE));
    assign accept    = ({1'b0, nxt} < LIMIT_W);
    assign forced    = !accept && (tries_nxt == TRIES_MX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= (seed_i == '0) ? WIDTH'(1) : seed_i;
            rand_q  <= '0;
            valid_q <= 1'b0;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
            tries_q <= tries_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_step) begin
            state_d = (accept || forced) ? ST_DONE : ST_GEN;
        end
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        rand_d  = rand_q;
        valid_d = valid_q;
        tries_d = tries_q;
        if (do_step) begin
            lfsr_d = nxt;
            if (accept) begin
                rand_d  = nxt;
                valid_d = 1'b1;
                tries_d = '0;
            end else if (forced) begin
                // nxt >= LIMIT here, so the modular subtraction is exact.
                rand_d  = nxt - LIMIT_LO;
                valid_d = 1'b1;
                tries_d = '0;
            end else begin
                valid_d = 1'b0;
                tries_d = tries_nxt;
            end
        end
    end

    assign rand_o  = rand_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == ST_GEN);

endmodule

// File: rtl/lfsr_rand_bank.sv
// Bank of NUM_CH independent range-limited LFSR channels for the old-film effect.
// Latency 1..MAX_TRIES cycles per draw; no backpressure, consumers sample while valid_o.
module lfsr_rand_bank
    import rng_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                NUM_CH    = 4,
    parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(DEF_TAPS),
    parameter int                LIMIT     = 900,
    parameter int                MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_rand_bank_if.slave   bus
);

    if ((2 * LIMIT < 2 ** WIDTH) || (LIMIT > 2 ** WIDTH) || (MAX_TRIES < 1)) begin : g_param_err
        $error("lfsr_rand_bank: LIMIT must lie in [2**WIDTH/2, 2**WIDTH] and MAX_TRIES >= 1");
    end

    logic [NUM_CH*WIDTH-1:0] rand_w;
    logic [NUM_CH-1:0]       valid_w;
    logic [NUM_CH-1:0]       gen_w;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        lfsr_rand_chan #(
            .WIDTH     (WIDTH),
            .TAPS      (TAPS),
            .LIMIT     (LIMIT),
            .MAX_TRIES (MAX_TRIES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .seed_i  (bus.seed_i[k*WIDTH +: WIDTH]),
            .frame_i (bus.frame_i),
            .mode_i  (bus.mode_i),
            .step_i  (bus.step_i[k]),
            .rand_o  (rand_w[k*WIDTH +: WIDTH]),
            .valid_o (valid_w[k]),
            .busy_o  (gen_w[k])
        );
    end

    assign bus.rand_o  = rand_w;
    assign bus.valid_o = valid_w;
    assign bus.busy_o  = |gen_w;

endmodule

// File: tb/tb_lfsr_rand_bank.sv
// Bench for lfsr_rand_bank: scoreboard of reference draws against two bank instances
// (MAX_TRIES 16 and 4) covering frame draws, stream redraws, restarts and reset.
module tb_lfsr_rand_bank;

    typedef struct {
        int         ch;
        logic [9:0] val;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    logic [9:0] a_seed [4];
    logic [9:0] ma_lfsr[4];
    logic [9:0] mb_lfsr;

    lfsr_rand_bank_if #(.WIDTH(10), .NUM_CH(4)) a_if ();
    lfsr_rand_bank_if #(.WIDTH(10), .NUM_CH(4)) b_if ();

    lfsr_rand_bank #(
        .WIDTH(10), .NUM_CH(4), .TAPS(10'b1100100001), .LIMIT(900), .MAX_TRIES(16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    lfsr_rand_bank #(
        .WIDTH(10), .NUM_CH(4), .TAPS(10'b1100100001), .LIMIT(900), .MAX_TRIES(4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference LFSR with the taps 9,8,5,0 written out explicitly.
    function automatic logic [9:0] step10(input logic [9:0] s);
        return {s[9] ^ s[8] ^ s[5] ^ s[0], s[9:1]};
    endfunction

    task automatic model_draw(input logic [9:0] lf_in, input int mt,
                              output logic [9:0] lf_out, output logic [9:0] v, output int lat);
        logic [9:0] lf;
        lf  = lf_in;
        v   = '0;
        lat = 0;
        for (int t = 1; t <= mt; t++) begin
            lf = step10(lf);
            if (lf < 10'd900) begin
                v   = lf;
                lat = t;
                break;
            end
            if (t == mt) begin
                v   = lf - 10'd900;
                lat = t;
            end
        end
        lf_out = lf;
    endtask

    task automatic init_models();
        for (int k = 0; k < 4; k++) ma_lfsr[k] = (a_seed[k] == 10'd0) ? 10'd1 : a_seed[k];
        mb_lfsr = 10'h3C1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_if.frame_i = 1'b0; a_if.step_i = '0; a_if.mode_i = 1'b0;
        b_if.frame_i = 1'b0; b_if.step_i = '0; b_if.mode_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rand_a",  a_if.rand_o,  0);
        check("rst_valid_a", a_if.valid_o, 0);
        check("rst_busy_a",  a_if.busy_o,  0);
        check("rst_rand_b",  b_if.rand_o,  0);
        check("rst_valid_b", b_if.valid_o, 0);
        rst = 1'b0;
        init_models();
    endtask

    // Frame draw on bank A: push reference results, then time each channel's valid.
    task automatic frame_a();
        exp_t       e;
        int         lat_obs[4];
        int         max_lat;
        int         l;
        logic [9:0] v, nl;
        bit         all_done;
        @(negedge clk);
        a_if.frame_i = 1'b1;
        max_lat = 0;
        for (int k = 0; k < 4; k++) begin
            model_draw(ma_lfsr[k], 16, nl, v, l);
            ma_lfsr[k] = nl;
            e.ch = k; e.val = v; e.lat = l;
            exp_q.push_back(e);
            if (l > max_lat) max_lat = l;
            lat_obs[k] = 0;
        end
        @(negedge clk);
        a_if.frame_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            check("busy", a_if.busy_o, (max_lat > c) ? 1 : 0);
            all_done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (lat_obs[k] == 0 && a_if.valid_o[k]) lat_obs[k] = c;
                if (lat_obs[k] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            check("draw_lat", lat_obs[e.ch], e.lat);
            check("draw_val", a_if.rand_o[e.ch*10 +: 10], e.val);
        end
    endtask

    task automatic wait_b_ch0(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (b_if.valid_o[0]) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        exp_t       e;
        logic [9:0] lf, nl, v, sval;
        int         l, tries, lat;
        bit         ev;

        n_checks = 0;
        n_errors = 0;
        a_seed[0] = 10'h001; a_seed[1] = 10'h3C1; a_seed[2] = 10'h000; a_seed[3] = 10'h2A5;
        rst = 1'b1;
        a_if.seed_i = {a_seed[3], a_seed[2], a_seed[1], a_seed[0]};
        b_if.seed_i = {10'h155, 10'h000, 10'h001, 10'h3C1};
        a_if.frame_i = 1'b0; a_if.mode_i = 1'b0; a_if.step_i = '0;
        b_if.frame_i = 1'b0; b_if.mode_i = 1'b0; b_if.step_i = '0;

        do_reset();

        // Frame-hold draws from seed 1 and a zero seed; then a long run for lock-up.
        frame_a();
        check("f1_ch0", a_if.rand_o[9:0], 512);
        check("f1_ch2_zero_seed", a_if.rand_o[29:20], 512);
        check("f1_ch1_3c1", a_if.rand_o[19:10], 511);
        frame_a();
        check("f2_ch0", a_if.rand_o[9:0], 768);
        frame_a();
        check("f3_ch0", a_if.rand_o[9:0], 384);
        repeat (1020) frame_a();

        // Stream mode: frame plus step_i[0] in the same cycle, then one step per cycle.
        do_reset();
        a_if.mode_i = 1'b1;
        @(negedge clk);
        a_if.frame_i = 1'b1;
        a_if.step_i  = 4'b0001;
        for (int k = 1; k < 4; k++) begin
            model_draw(ma_lfsr[k], 16, nl, v, l);
            ma_lfsr[k] = nl;
        end
        lf = ma_lfsr[0];
        tries = 0;
        sval = '0;
        for (int i = 0; i < 200; i++) begin
            lf = step10(lf);
            tries++;
            if (lf < 10'd900) begin
                ev = 1'b1; sval = lf; tries = 0;
            end else if (tries == 16) begin
                ev = 1'b1; sval = lf - 10'd900; tries = 0;
            end else begin
                ev = 1'b0;
            end
            e.ch = 0; e.val = sval; e.lat = ev ? 1 : 0;
            exp_q.push_back(e);
            @(negedge clk);
            a_if.frame_i = 1'b0;
            e = exp_q.pop_front();
            check("strm_vld", a_if.valid_o[0], e.lat);
            check("strm_val", a_if.rand_o[9:0], e.val);
            if (i == 0) check("strm_s0", a_if.rand_o[9:0], 512);
            if (i == 1) check("strm_s1", a_if.rand_o[9:0], 768);
            if (i == 2) check("strm_s2", a_if.rand_o[9:0], 384);
            if (i >= 30 && ev) begin
                a_if.step_i = '0;
                break;
            end
        end
        ma_lfsr[0] = lf;

        // step_i ignored in frame-hold mode.
        a_if.mode_i = 1'b0;
        a_if.step_i = 4'hF;
        repeat (6) begin
            @(negedge clk);
            check("hold_vld", a_if.valid_o, 4'hF);
            check("hold_val", a_if.rand_o[9:0], sval);
        end
        a_if.step_i = '0;
        frame_a();

        // MAX_TRIES = 4: forced accept on the 4th step.
        do_reset();
        @(negedge clk);
        b_if.frame_i = 1'b1;
        model_draw(mb_lfsr, 4, nl, v, l);
        mb_lfsr = nl;
        e.ch = 0; e.val = v; e.lat = l;
        exp_q.push_back(e);
        @(negedge clk);
        b_if.frame_i = 1'b0;
        wait_b_ch0(lat);
        e = exp_q.pop_front();
        check("forced_lat", lat, e.lat);
        check("forced_val", b_if.rand_o[9:0], e.val);
        check("forced_120", b_if.rand_o[9:0], 120);

        // Frame during GEN restarts the try budget: forced accept moves to 1023-900.
        do_reset();
        @(negedge clk);
        b_if.frame_i = 1'b1;
        @(negedge clk);
        b_if.frame_i = 1'b0;
        check("gen_c1_vld", b_if.valid_o[0], 0);
        @(negedge clk);
        check("gen_c2_vld", b_if.valid_o[0], 0);
        check("gen_c2_busy", b_if.busy_o, 1);
        b_if.frame_i = 1'b1;
        model_draw(step10(step10(10'h3C1)), 4, nl, v, l);
        e.ch = 0; e.val = v; e.lat = l;
        exp_q.push_back(e);
        @(negedge clk);
        b_if.frame_i = 1'b0;
        wait_b_ch0(lat);
        e = exp_q.pop_front();
        check("restart_lat", lat, e.lat);
        check("restart_val", b_if.rand_o[9:0], e.val);
        check("restart_123", b_if.rand_o[9:0], 123);

        // Reset mid-draw returns to reset values and reloads the seeds.
        do_reset();
        @(negedge clk);
        a_if.frame_i = 1'b1;
        @(negedge clk);
        a_if.frame_i = 1'b0;
        @(negedge clk);
        check("mid_busy", a_if.busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rand",  a_if.rand_o,  0);
        check("mid_rst_valid", a_if.valid_o, 0);
        check("mid_rst_busy",  a_if.busy_o,  0);
        rst = 1'b0;
        init_models();
        frame_a();
        check("reseed_ch0", a_if.rand_o[9:0], 512);
        check("reseed_ch1", a_if.rand_o[19:10], 511);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
